// File: rtl/cpu_stim_gen.sv
// Programmable stimulus/monitor harness for the CPU I/O and interrupt ports:
// per-channel pattern generator, periodic interrupt-enable pulser and output-change counter.
module cpu_stim_gen #(
    parameter int unsigned   NCH       = 4,
    parameter int unsigned   DW        = 8,
    parameter int unsigned   CNT_W     = 20,
    parameter int unsigned   TIMEOUT   = 500002,
    parameter logic [DW-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_ch,
    input  logic [1:0]         cfg_sel,
    input  logic [15:0]        cfg_data,
    input  logic [NCH*DW-1:0]  cpu_out,
    input  logic [3:0]         mon_ch,
    output logic [NCH*DW-1:0]  stim,
    output logic [NCH-1:0]     ie,
    output logic [15:0]        mon_cnt,
    output logic [CNT_W-1:0]   cycles,
    output logic               done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_INC  = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_ECHO = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             run;
    logic [CNT_W-1:0] cycles_inc;
    logic [15:0]      chg_arr [NCH];

    assign run        = en && !done;
    assign cycles_inc = cycles + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
            done   <= 1'b0;
        end else if (run) begin
            cycles <= cycles_inc;
            if (cycles_inc == TIMEOUT_C) begin
                done <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        mode_t         mode_q;
        logic [DW-1:0] base_q;
        logic [DW-1:0] stim_q;
        logic [DW-1:0] prev_q;
        logic [DW-1:0] next_gen;
        logic [DW-1:0] cur;
        logic [15:0]   period_q;
        logic [15:0]   irq_cnt;
        logic [15:0]   chg_cnt;
        logic          ie_q;
        logic          hit;

        assign cur = cpu_out[k*DW +: DW];
        assign hit = cfg_we && (cfg_ch == 4'(k));

        always_comb begin
            next_gen = base_q;
            unique case (mode_q)
                MODE_HOLD: next_gen = base_q;
                MODE_INC:  next_gen = stim_q + 1'b1;
                MODE_LFSR: begin
                    // zero would lock the LFSR, so it escapes to 1
                    if (stim_q == '0) begin
                        next_gen = {{(DW-1){1'b0}}, 1'b1};
                    end else if (stim_q[0]) begin
                        next_gen = (stim_q >> 1) ^ LFSR_TAPS;
                    end else begin
                        next_gen = stim_q >> 1;
                    end
                end
                MODE_ECHO: next_gen = cur;
                default:   next_gen = base_q;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mode_q   <= MODE_HOLD;
                base_q   <= '0;
                stim_q   <= '0;
                prev_q   <= '0;
                period_q <= '0;
                irq_cnt  <= '0;
                chg_cnt  <= '0;
                ie_q     <= 1'b0;
            end else begin
                if (run) begin
                    stim_q <= next_gen;
                    prev_q <= cur;
                    if ((cur != prev_q) && (chg_cnt != '1)) begin
                        chg_cnt <= chg_cnt + 1'b1;
                    end
                    if (period_q == '0) begin
                        ie_q <= 1'b0;
                    end else if (irq_cnt <= 16'd1) begin
                        ie_q    <= 1'b1;
                        irq_cnt <= period_q;
                    end else begin
                        ie_q    <= 1'b0;
                        irq_cnt <= irq_cnt - 1'b1;
                    end
                end else begin
                    ie_q <= 1'b0;
                end

                // config writes come last so they override the run-time update
                if (hit) begin
                    case (cfg_sel)
                        2'd0: begin
                            mode_q <= mode_t'(cfg_data[1:0]);
                            if (!done) begin
                                stim_q <= base_q;
                            end
                        end
                        2'd1: begin
                            base_q <= cfg_data[DW-1:0];
                            if (!done) begin
                                stim_q <= cfg_data[DW-1:0];
                            end
                        end
                        2'd2: begin
                            period_q <= cfg_data;
                            irq_cnt  <= cfg_data;
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign stim[k*DW +: DW] = stim_q;
        assign ie[k]            = ie_q;
        assign chg_arr[k]       = chg_cnt;
    end

    always_comb begin
        mon_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (mon_ch == 4'(i)) begin
                mon_cnt = chg_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_cpu_stim_gen.sv
// Self-checking bench for cpu_stim_gen: expected values queued at stimulus time,
// popped and compared once the DUT has clocked.
module tb_cpu_stim_gen;

    localparam int unsigned NCH     = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [1:0]        cfg_sel;
    logic [15:0]       cfg_data;
    logic [NCH*DW-1:0] cpu_out;
    logic [3:0]        mon_ch;
    logic [NCH*DW-1:0] stim;
    logic [NCH-1:0]    ie;
    logic [15:0]       mon_cnt;
    logic [CNT_W-1:0]  cycles;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_stim_gen #(
        .NCH      (NCH),
        .DW       (DW),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .LFSR_TAPS(8'hB8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_sel (cfg_sel),
        .cfg_data(cfg_data),
        .cpu_out (cpu_out),
        .mon_ch  (mon_ch),
        .stim    (stim),
        .ie      (ie),
        .mon_cnt (mon_cnt),
        .cycles  (cycles),
        .done    (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        en       = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_sel  = '0;
        cfg_data = '0;
        cpu_out  = '0;
        mon_ch   = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [1:0] sel, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_sel  = sel;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_out = $urandom;
            en      = 1'b1;
            tick();
        end
        checks++;
        if (stim !== '0) begin errors++; $display("FAIL reset_stim: got %h want 0", stim); end
        checks++;
        if (ie !== '0) begin errors++; $display("FAIL reset_ie: got %b want 0", ie); end
        checks++;
        if (cycles !== '0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        for (int c = 0; c < NCH; c++) begin
            mon_ch = 4'(c);
            #1;
            checks++;
            if (mon_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_mon_cnt[%0d]: got %0d want 0", c, mon_cnt);
            end
        end
        en      = 1'b0;
        cpu_out = '0;
        reset   = 1'b1;
        tick();
    endtask

    task automatic test_inc_wrap();
        logic [DW-1:0] model;
        logic [31:0]   exp;
        apply_reset();
        cfg_write(4'd1, 2'd1, 16'h00FD);
        cfg_write(4'd1, 2'd0, 16'd1);
        model = 8'hFD;
        exp_q.push_back(32'(model));
        exp = exp_q.pop_front();
        checks++;
        if (stim[1*DW +: DW] !== exp[DW-1:0]) begin
            errors++; $display("FAIL inc_load: got %h want %h", stim[1*DW +: DW], exp[DW-1:0]);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model = model + 1'b1;
            exp_q.push_back(32'(model));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (stim[1*DW +: DW] !== exp[DW-1:0]) begin
                errors++; $display("FAIL inc_step%0d: got %h want %h", i, stim[1*DW +: DW], exp[DW-1:0]);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'(model));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (stim[1*DW +: DW] !== exp[DW-1:0]) begin
                errors++; $display("FAIL inc_hold%0d: got %h want %h", i, stim[1*DW +: DW], exp[DW-1:0]);
            end
        end
    endtask

    task automatic test_lfsr();
        logic [DW-1:0] seq [4];
        logic [31:0]   exp;
        seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        apply_reset();
        cfg_write(4'd2, 2'd1, 16'h0000);
        cfg_write(4'd2, 2'd0, 16'd2);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(seq[i]));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (stim[2*DW +: DW] !== exp[DW-1:0]) begin
                errors++; $display("FAIL lfsr_step%0d: got %h want %h", i, stim[2*DW +: DW], exp[DW-1:0]);
            end
        end
        en = 1'b0;
        exp_q.push_back(32'h01);
        cfg_write(4'd2, 2'd1, 16'h0001);
        exp = exp_q.pop_front();
        checks++;
        if (stim[2*DW +: DW] !== exp[DW-1:0]) begin
            errors++; $display("FAIL lfsr_reload: got %h want %h", stim[2*DW +: DW], exp[DW-1:0]);
        end
    endtask

    task automatic test_irq();
        logic [31:0] exp;
        apply_reset();
        cfg_write(4'd0, 2'd2, 16'd3);
        en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back((k % 3 == 0) ? 32'd1 : 32'd0);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (ie !== exp[NCH-1:0]) begin
                errors++; $display("FAIL irq_p3_cycle%0d: got %b want %b", k, ie, exp[NCH-1:0]);
            end
        end
        cfg_write(4'd0, 2'd2, 16'd0);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(32'd0);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (ie !== exp[NCH-1:0]) begin
                errors++; $display("FAIL irq_p0_%0d: got %b want %b", k, ie, exp[NCH-1:0]);
            end
        end
        cfg_write(4'd0, 2'd2, 16'd1);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'd1);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (ie !== exp[NCH-1:0]) begin
                errors++; $display("FAIL irq_p1_%0d: got %b want %b", k, ie, exp[NCH-1:0]);
            end
        end
        en = 1'b0;
        exp_q.push_back(32'd0);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (ie !== exp[NCH-1:0]) begin
            errors++; $display("FAIL irq_en_drop: got %b want %b", ie, exp[NCH-1:0]);
        end
    endtask

    task automatic test_echo_monitor();
        logic [DW-1:0] vals [5];
        logic [31:0]   exp;
        logic [DW-1:0] prev;
        int            changes;
        vals = '{8'h10, 8'h10, 8'h22, 8'h22, 8'h35};
        apply_reset();
        cfg_write(4'd3, 2'd0, 16'd3);
        mon_ch  = 4'd3;
        en      = 1'b1;
        prev    = '0;
        changes = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_out[3*DW +: DW] = vals[i];
            if (vals[i] != prev) changes++;
            prev = vals[i];
            exp_q.push_back(32'(vals[i]));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (stim[3*DW +: DW] !== exp[DW-1:0]) begin
                errors++; $display("FAIL echo_%0d: got %h want %h", i, stim[3*DW +: DW], exp[DW-1:0]);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (mon_cnt !== 16'(changes)) begin
            errors++; $display("FAIL mon_cnt_ch3: got %0d want %0d", mon_cnt, changes);
        end
        mon_ch = 4'd2;
        #1;
        checks++;
        if (mon_cnt !== 16'd0) begin errors++; $display("FAIL mon_cnt_ch2: got %0d want 0", mon_cnt); end
        mon_ch = 4'd9;
        #1;
        checks++;
        if (mon_cnt !== 16'd0) begin errors++; $display("FAIL mon_cnt_oob: got %0d want 0", mon_cnt); end
    endtask

    task automatic test_timeout();
        int edges;
        apply_reset();
        cfg_write(4'd1, 2'd0, 16'd1);
        cfg_write(4'd0, 2'd2, 16'd1);
        en    = 1'b1;
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (done !== 1'b1 || edges != TIMEOUT) begin
            errors++; $display("FAIL timeout_edge: done=%b after %0d edges want 1 after %0d", done, edges, TIMEOUT);
        end
        checks++;
        if (cycles !== CNT_W'(TIMEOUT)) begin
            errors++; $display("FAIL timeout_cycles: got %0d want %0d", cycles, TIMEOUT);
        end
        checks++;
        if (stim[1*DW +: DW] !== 8'h14) begin
            errors++; $display("FAIL timeout_stim: got %h want 14", stim[1*DW +: DW]);
        end
        tick();
        tick();
        checks++;
        if (cycles !== CNT_W'(TIMEOUT) || ie !== '0 || stim[1*DW +: DW] !== 8'h14) begin
            errors++; $display("FAIL frozen: cycles=%0d ie=%b stim1=%h want %0d 0 14", cycles, ie, stim[1*DW +: DW], TIMEOUT);
        end
        cfg_write(4'd1, 2'd1, 16'h0055);
        checks++;
        if (stim[1*DW +: DW] !== 8'h14) begin
            errors++; $display("FAIL frozen_cfg: got %h want 14", stim[1*DW +: DW]);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || cycles !== '0 || stim !== '0) begin
            errors++; $display("FAIL async_reset: done=%b cycles=%0d stim=%h want 0 0 0", done, cycles, stim);
        end
        en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_sel  = '0;
        cfg_data = '0;
        cpu_out  = '0;
        mon_ch   = '0;
        #2;
        test_reset();
        test_inc_wrap();
        test_lfsr();
        test_irq();
        test_echo_monitor();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
